// File: rtl/mem_port_sched_pkg.sv
// Shared types and default parameters for the instruction/data memory port scheduler.
package mem_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } sched_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  localparam int MEM_LAT_DEF    = 1;
  localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/mem_port_sched_starve_counter.sv
// Saturating count of data grants won against a pending fetch; at_max forces the next conflict to fetch.
module starve_counter #(
  parameter int STARVE_MAX = 4
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              inc,
  input  logic                              clr,
  output logic                              at_max,
  output logic [$clog2(STARVE_MAX+1)-1:0]   count
);

  localparam int W = $clog2(STARVE_MAX + 1);
  localparam logic [W-1:0] MAX_V = W'(STARVE_MAX);

  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count < MAX_V)) begin
      count <= count + 1'b1;
    end
  end

  assign at_max = (count >= MAX_V);

endmodule

// File: rtl/mem_port_sched.sv
// Time-shares the single memory port between instruction fetch and data load/store requesters.
module mem_port_sched
  import mem_sched_pkg::*;
#(
  parameter int MEM_LAT    = MEM_LAT_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_ack,
  output logic [31:0] dm_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  sched_state_t state, state_nxt;
  owner_t       owner_q;
  logic         we_q;
  logic [31:0]  rdata_q;
  logic [3:0]   wait_cnt;
  logic         wait_last;
  logic         any_req;
  logic         grant_dm;
  logic         grant_if;
  logic         at_max;
  logic [$clog2(STARVE_MAX+1)-1:0] starve_cnt;

  assign any_req   = if_req || dm_req;
  // Data keeps the port on a conflict until it has won STARVE_MAX times in a row.
  assign grant_dm  = (state == IDLE) && dm_req && (!if_req || !at_max);
  assign grant_if  = (state == IDLE) && if_req && !grant_dm;
  assign wait_last = (wait_cnt == 4'(MEM_LAT - 1));

  starve_counter #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clock  (clock),
    .reset  (reset),
    .inc    (grant_dm && if_req),
    .clr    (grant_if),
    .at_max (at_max),
    .count  (starve_cnt)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      owner_q   <= OWN_IF;
      we_q      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata_q   <= '0;
      wait_cnt  <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (grant_dm) begin
            owner_q   <= OWN_DM;
            we_q      <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
          end else if (grant_if) begin
            owner_q  <= OWN_IF;
            we_q     <= 1'b0;
            mem_addr <= if_addr;
          end
        end
        ACCESS: begin
          if (!we_q) begin
            if (wait_last) rdata_q <= mem_rdata;
            else           wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  if (we_q || wait_last) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy     = (state != IDLE);
  assign mem_wr   = (state == ACCESS) && we_q;
  assign if_ack   = (state == ACK) && (owner_q == OWN_IF);
  assign dm_ack   = (state == ACK) && (owner_q == OWN_DM);
  assign if_rdata = rdata_q;
  assign dm_rdata = rdata_q;

endmodule

// File: tb/tb_mem_port_sched.sv
// Directed bench: default-latency instance (reset, arbitration, load, store) and MEM_LAT=3 instance (fetch, reset abort).
module tb_mem_port_sched;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic        a_reset, a_if_req, a_if_ack, a_dm_req, a_dm_we, a_dm_ack, a_mem_wr, a_busy;
  logic [31:0] a_if_addr, a_if_rdata, a_dm_addr, a_dm_wdata, a_dm_rdata;
  logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;

  logic        b_reset, b_if_req, b_if_ack, b_dm_req, b_dm_we, b_dm_ack, b_mem_wr, b_busy;
  logic [31:0] b_if_addr, b_if_rdata, b_dm_addr, b_dm_wdata, b_dm_rdata;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

  mem_port_sched #(.MEM_LAT(1), .STARVE_MAX(4)) u_a (
    .clock(clock), .reset(a_reset),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_ack(a_if_ack), .if_rdata(a_if_rdata),
    .dm_req(a_dm_req), .dm_we(a_dm_we), .dm_addr(a_dm_addr), .dm_wdata(a_dm_wdata),
    .dm_ack(a_dm_ack), .dm_rdata(a_dm_rdata),
    .mem_addr(a_mem_addr), .mem_wr(a_mem_wr), .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata),
    .busy(a_busy)
  );

  mem_port_sched #(.MEM_LAT(3), .STARVE_MAX(4)) u_b (
    .clock(clock), .reset(b_reset),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_ack(b_if_ack), .if_rdata(b_if_rdata),
    .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata),
    .dm_ack(b_dm_ack), .dm_rdata(b_dm_rdata),
    .mem_addr(b_mem_addr), .mem_wr(b_mem_wr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
    .busy(b_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Expected grant order under continuous conflict: 1 = data, 0 = fetch.
  logic [9:0] exp_dm_order = 10'b1111011110;
  logic       got_dm;
  logic       seen;

  initial begin
    a_reset = 1'b0; a_if_req = 1'b1; a_dm_req = 1'b1; a_dm_we = 1'b0;
    a_if_addr = 32'h0000_0100; a_dm_addr = 32'h0000_0040; a_dm_wdata = 32'h0;
    a_mem_rdata = 32'h1111_2222;
    b_reset = 1'b0; b_if_req = 1'b0; b_dm_req = 1'b0; b_dm_we = 1'b0;
    b_if_addr = 32'h0; b_dm_addr = 32'h0; b_dm_wdata = 32'h0; b_mem_rdata = 32'h0;

    // Reset held two cycles with both requests high.
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_busy",   {31'b0, a_busy},   32'd0);
      check("rst_acks",   {30'b0, a_if_ack, a_dm_ack}, 32'd0);
      check("rst_mem_wr", {31'b0, a_mem_wr}, 32'd0);
      check("rst_addr",   a_mem_addr,  32'd0);
      check("rst_wdata",  a_mem_wdata, 32'd0);
      check("rst_rdata",  a_dm_rdata,  32'd0);
    end
    a_reset = 1'b1;
    b_reset = 1'b1;

    // Continuous conflict: four data grants then one fetch, twice.
    for (int t = 0; t < 10; t++) begin
      seen = 1'b0;
      for (int c = 0; c < 8 && !seen; c++) begin
        tick();
        seen = a_if_ack | a_dm_ack;
      end
      check($sformatf("conf_ack_seen%0d", t), {31'b0, seen}, 32'd1);
      got_dm = a_dm_ack;
      check($sformatf("conf_grant%0d", t), {31'b0, got_dm}, {31'b0, exp_dm_order[9-t]});
      if (t == 3) check("starve_at_max", 32'(u_a.u_starve.count), 32'd4);
      if (t == 4) check("starve_clr",    32'(u_a.u_starve.count), 32'd0);
    end
    a_if_req = 1'b0;
    a_dm_req = 1'b0;
    tick();
    check("idle_after_conf", {31'b0, a_busy}, 32'd0);

    // Single load from 0x40.
    a_dm_req = 1'b1; a_dm_we = 1'b0; a_dm_addr = 32'h0000_0040; a_mem_rdata = 32'hDEAD_BEEF;
    tick();
    check("ld_c1_addr", a_mem_addr, 32'h0000_0040);
    check("ld_c1_wr",   {31'b0, a_mem_wr}, 32'd0);
    check("ld_c1_ack",  {31'b0, a_dm_ack}, 32'd0);
    check("ld_c1_busy", {31'b0, a_busy},   32'd1);
    tick();
    check("ld_c2_dmack", {31'b0, a_dm_ack}, 32'd1);
    check("ld_c2_ifack", {31'b0, a_if_ack}, 32'd0);
    check("ld_c2_rdata", a_dm_rdata, 32'hDEAD_BEEF);
    a_dm_req = 1'b0;
    tick();
    check("ld_c3_ack",  {31'b0, a_dm_ack}, 32'd0);
    check("ld_c3_busy", {31'b0, a_busy},   32'd0);

    // Store to 0x80; read data must be left alone.
    a_dm_req = 1'b1; a_dm_we = 1'b1; a_dm_addr = 32'h0000_0080; a_dm_wdata = 32'h1234_5678;
    a_mem_rdata = 32'hCAFE_F00D;
    tick();
    check("st_c1_wr",    {31'b0, a_mem_wr}, 32'd1);
    check("st_c1_addr",  a_mem_addr,  32'h0000_0080);
    check("st_c1_wdata", a_mem_wdata, 32'h1234_5678);
    tick();
    check("st_c2_wr",    {31'b0, a_mem_wr}, 32'd0);
    check("st_c2_ack",   {31'b0, a_dm_ack}, 32'd1);
    check("st_c2_rdata", a_dm_rdata, 32'hDEAD_BEEF);
    a_dm_req = 1'b0;
    tick();
    check("st_c3_busy", {31'b0, a_busy}, 32'd0);
    check("st_c3_addr", a_mem_addr, 32'h0000_0080);

    // MEM_LAT=3 fetch of 0x100.
    b_if_req = 1'b1; b_if_addr = 32'h0000_0100; b_mem_rdata = 32'hA5A5_0100;
    for (int c = 1; c <= 3; c++) begin
      tick();
      check($sformatf("f3_c%0d_busy", c), {31'b0, b_busy},   32'd1);
      check($sformatf("f3_c%0d_ack", c),  {31'b0, b_if_ack}, 32'd0);
      check($sformatf("f3_c%0d_addr", c), b_mem_addr, 32'h0000_0100);
    end
    tick();
    check("f3_c4_ack",   {31'b0, b_if_ack}, 32'd1);
    check("f3_c4_busy",  {31'b0, b_busy},   32'd1);
    check("f3_c4_rdata", b_if_rdata, 32'hA5A5_0100);
    b_if_req = 1'b0;
    tick();
    check("f3_c5_busy", {31'b0, b_busy}, 32'd0);

    // MEM_LAT=3 load aborted by reset in its first ACCESS cycle.
    b_dm_req = 1'b1; b_dm_we = 1'b0; b_dm_addr = 32'h0000_0200;
    tick();
    check("ab_c1_busy", {31'b0, b_busy}, 32'd1);
    b_reset  = 1'b0;
    b_dm_req = 1'b0;
    tick();
    check("ab_rst_busy",  {31'b0, b_busy},   32'd0);
    check("ab_rst_ack",   {31'b0, b_dm_ack}, 32'd0);
    check("ab_rst_rdata", b_dm_rdata, 32'd0);
    b_reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("ab_post%0d_ack", c), {30'b0, b_if_ack, b_dm_ack}, 32'd0);
    end
    check("ab_post_rdata", b_dm_rdata, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_sched.md
# mem_port_sched

Scheduler that time-shares the CPU's single memory port between the instruction-fetch requester and the data (load/store) requester. It sits between the multicycle control/datapath and `Memoria`. It arbitrates competing requests, sequences the memory read-latency wait states, and returns read data and a one-cycle acknowledge to the winning requester.

## Interface
Parameters:
- `MEM_LAT`, default 1: cycles from address presented to `mem_rdata` valid. Legal range 1–15.
- `STARVE_MAX`, default 4: consecutive data grants made while `if_req` is pending before fetch is forced to win.

Ports:
- `clock`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-low
- `if_req`  in  1  fetch request; held until `if_ack`
- `if_addr`  in  32  fetch address
- `if_ack`  out  1  one-cycle fetch completion pulse
- `if_rdata`  out  32  fetched word; valid when `if_ack`=1
- `dm_req`  in  1  data request; held until `dm_ack`
- `dm_we`  in  1  1 = store, 0 = load
- `dm_addr`  in  32  data address
- `dm_wdata`  in  32  store data
- `dm_ack`  out  1  one-cycle data completion pulse
- `dm_rdata`  out  32  loaded word; valid when `dm_ack`=1
- `mem_addr`  out  32  address to `Memoria`
- `mem_wr`  out  1  write strobe to `Memoria`
- `mem_wdata`  out  32  write data to `Memoria`
- `mem_rdata`  in  32  read data from `Memoria`
- `busy`  out  1  1 in any state other than IDLE

## Operation
- FSM states: IDLE, ACCESS, ACK.
- **IDLE**
  - If any request is present, latch the winner's owner, address, write enable and write data.
  - Clear the wait counter, then go to ACCESS.
- **Arbitration**
  - A lone request wins.
  - On a conflict, data wins while `starve_cnt` < `STARVE_MAX`; otherwise fetch wins.
- **Starvation counter** (`starve_cnt`)
  - Increments, saturating at `STARVE_MAX`, on each data grant made while `if_req`=1.
  - Clears to 0 on any fetch grant.
- **ACCESS**
  - `mem_addr`, `mem_wdata` are driven from the latched registers.
  - Store: `mem_wr`=1 for exactly one cycle, then go to ACK.
  - Load: `mem_wr`=0; wait counter runs 0..`MEM_LAT`-1. On the last cycle, capture `mem_rdata` into the read-data register and go to ACK.
- **ACK**
  - Assert the owner's ack for one cycle, then go to IDLE.
- Read data:
  - `if_rdata` and `dm_rdata` are both driven from the single read-data register.
  - The register holds its value until the next load capture; a store does not change it.
- Requesters must present `req` low in the IDLE cycle that follows their ack. A request still high in IDLE is treated as a new transaction.
- Request inputs are sampled only in IDLE. Changes during ACCESS or ACK are ignored.
- `mem_addr`/`mem_wdata` retain their last latched values in IDLE and ACK. `mem_wr`=0 outside the store ACCESS cycle.
- Reset values (after any edge with `reset`=0):
  - state IDLE; all acks 0, `mem_wr` 0, `busy` 0
  - `mem_addr`, `mem_wdata`, `if_rdata`, `dm_rdata` all 0
  - `starve_cnt` 0; wait counter 0
- Reset mid-operation aborts the transaction and no ack is issued. A store whose ACCESS cycle preceded the reset edge has already been written.

## Timing
- Cycle 0 is the IDLE cycle in which the request is sampled.
- Load latency: ACCESS occupies cycles 1..`MEM_LAT`; ack in cycle `MEM_LAT`+1. With the default, ack is in cycle 2.
- Store latency: ACCESS in cycle 1, ack in cycle 2, independent of `MEM_LAT`.
- Back-to-back throughput: a new transaction can start in the IDLE cycle after ACK. A load occupies `MEM_LAT`+2 cycles; a store occupies 3 cycles.
- All outputs are registered or decoded from state only; there is no combinational path from request inputs to outputs.

## Structure
- Package `mem_sched_pkg` holds:
  - the state enum (IDLE/ACCESS/ACK)
  - the owner encoding (OWN_IF/OWN_DM)
  - default constants for `MEM_LAT` and `STARVE_MAX`
- Sub-module `starve_counter` holds the saturating counter, with inputs `inc`, `clr` and output `at_max`.
- The FSM, latches and wait counter stay in `mem_port_sched`.

## Test plan
- Reset: hold `reset`=0 for 2 cycles with both requests high → all outputs 0, `busy`=0, no ack; after release, data is granted first.
- Single load: `dm_req`=1, `dm_we`=0, `dm_addr`=0x40, memory returns 0xDEADBEEF → `mem_addr`=0x40 in cycle 1, `dm_ack` in cycle 2, `dm_rdata`=0xDEADBEEF, `if_ack` stays 0.
- Store: `dm_we`=1, `dm_addr`=0x80, `dm_wdata`=0x12345678 → `mem_wr`=1 for exactly cycle 1 with that address/data, `dm_ack` in cycle 2, `dm_rdata` unchanged.
- Conflict and starvation, `STARVE_MAX`=4: `if_req` and `dm_req` continuously high → grant order DM, DM, DM, DM, IF, then the pattern repeats; `starve_cnt` returns to 0 after the IF grant.
- `MEM_LAT`=3 fetch of 0x100 → ACCESS lasts cycles 1–3, `if_ack` in cycle 4, `busy`=1 in cycles 1–4.
- Reset in cycle 1 of a `MEM_LAT`=3 load → no ack is issued, state is IDLE on the next cycle, and `dm_rdata` is 0.
